// File: rtl/mem_request_initiator.sv
// Initiator FSM for the start/done/active memory-controller protocol: one request at a time, legality check, one-cycle response.
// Optional WAIT-state timeout (and its TIMEOUT_CYCLES parameter) is compiled in with `define MEM_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_request_initiator
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_address,
    input  logic [2:0]  req_mode,
    input  logic        req_write,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        mem_start,
    output logic [31:0] mem_address,
    output logic [2:0]  mem_mode,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic        mem_done,
    input  logic [31:0] mem_read_data,
    input  logic        mem_active
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t      state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_error_q;
    logic        mem_start_q;
    logic [31:0] mem_address_q;
    logic [2:0]  mem_mode_q;
    logic        mem_we_q;
    logic [31:0] mem_wdata_q;
`ifdef MEM_TIMEOUT_EN
    logic [7:0]  wait_cnt_q;
`endif

    logic mode_legal;
    logic misaligned;
    logic req_bad;

    // Busy flag from the controller is observed only; the FSM relies on done alone.
    logic unused_mem_active;
    assign unused_mem_active = mem_active;

    assign mode_legal = req_write ? (req_mode inside {3'b000, 3'b001, 3'b010})
                                  : (req_mode inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    assign misaligned = ((req_mode[1:0] == 2'b01) && req_address[0]) ||
                        ((req_mode[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
    assign req_bad    = !mode_legal || misaligned;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'd0;
            rsp_error_q   <= 1'b0;
            mem_start_q   <= 1'b0;
            mem_address_q <= 32'd0;
            mem_mode_q    <= 3'd0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= 32'd0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt_q    <= 8'd0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        mem_address_q <= req_address;
                        mem_mode_q    <= req_mode;
                        mem_we_q      <= req_write;
                        mem_wdata_q   <= req_wdata;
                        req_ready_q   <= 1'b0;
                        if (req_bad) begin
                            state_q     <= S_ERROR;
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_rdata_q <= 32'd0;
                        end else begin
                            state_q     <= S_ISSUE;
                            mem_start_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    mem_start_q <= 1'b0;
                    state_q     <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
                    wait_cnt_q  <= 8'd0;
`endif
                end
                S_WAIT: begin
                    // A done in the final timeout cycle still completes normally.
                    if (mem_done) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b0;
                        rsp_rdata_q <= mem_we_q ? 32'd0 : mem_read_data;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                        state_q     <= S_ERROR;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        rsp_rdata_q <= 32'd0;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + 8'd1;
                    end
`endif
                end
                S_RESP, S_ERROR: begin
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    mem_start_q <= 1'b0;
                    req_ready_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready        = req_ready_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_rdata        = rsp_rdata_q;
    assign rsp_error        = rsp_error_q;
    assign mem_start        = mem_start_q;
    assign mem_address      = mem_address_q;
    assign mem_mode         = mem_mode_q;
    assign mem_write_enable = mem_we_q;
    assign mem_write_data   = mem_wdata_q;

endmodule

// File: tb/tb_mem_request_initiator.sv
// Directed self-checking bench for mem_request_initiator; the controller side is played inline by each scenario task.
`timescale 1ns/1ps
module tb_mem_request_initiator;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_address;
    logic [2:0]  req_mode;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        mem_start;
    logic [31:0] mem_address;
    logic [2:0]  mem_mode;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic        mem_done;
    logic [31:0] mem_read_data;
    logic        mem_active;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;
    int rsp_cnt = 0;

    // Illegal / misaligned request table: {write, mode, address}
    logic        bad_we   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [2:0]  bad_mode [6] = '{3'b011, 3'b100, 3'b010, 3'b010, 3'b001, 3'b110};
    logic [31:0] bad_addr [6] = '{32'h0, 32'h0, 32'h102, 32'h203, 32'h5, 32'h10};

    mem_request_initiator dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_address      (req_address),
        .req_mode         (req_mode),
        .req_write        (req_write),
        .req_wdata        (req_wdata),
        .rsp_valid        (rsp_valid),
        .rsp_rdata        (rsp_rdata),
        .rsp_error        (rsp_error),
        .mem_start        (mem_start),
        .mem_address      (mem_address),
        .mem_mode         (mem_mode),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_done         (mem_done),
        .mem_read_data    (mem_read_data),
        .mem_active       (mem_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (mem_start === 1'b1) start_cnt++;
        if (rsp_valid === 1'b1) rsp_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, want summary");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offers one request and returns in cycle +1 after the transfer edge.
    task automatic drive_req(input logic [31:0] addr, input logic [2:0] mode,
                             input logic wr, input logic [31:0] wdata);
        req_valid   = 1'b1;
        req_address = addr;
        req_mode    = mode;
        req_write   = wr;
        req_wdata   = wdata;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_address = '0; req_mode = '0; req_write = 1'b0;
        req_wdata = '0; mem_done = 1'b0; mem_read_data = '0; mem_active = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        n_vec++;
        if ({rsp_valid, rsp_error, mem_start, mem_write_enable, mem_mode} !== 7'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 0000000",
                              {rsp_valid, rsp_error, mem_start, mem_write_enable, mem_mode});
        end
        n_vec++;
        if ({rsp_rdata, mem_address, mem_write_data} !== 96'd0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h want 0 0 0", rsp_rdata, mem_address, mem_write_data);
        end
        rst_n = 1'b1;
        tick();
        $display("txn reset          ready=%b rsp_valid=%b", req_ready, rsp_valid);
    endtask

    task automatic test_store_half;
        int s0 = start_cnt;
        int r0 = rsp_cnt;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL sh_ready: got %b want 1", req_ready);
        end
        drive_req(32'h202, 3'b001, 1'b1, 32'h1234ABCD);
        n_vec++;
        if ({mem_start, mem_write_enable, mem_mode} !== 5'b1_1_001) begin
            n_err++; $display("FAIL sh_issue: got start/we/mode %b want 11001", {mem_start, mem_write_enable, mem_mode});
        end
        n_vec++;
        if (mem_address !== 32'h202 || mem_write_data !== 32'h1234ABCD) begin
            n_err++; $display("FAIL sh_bus: got %h/%h want 00000202/1234abcd", mem_address, mem_write_data);
        end
        tick();
        n_vec++;
        if ({mem_start, mem_write_enable, mem_mode, rsp_valid} !== 6'b0_1_001_0) begin
            n_err++; $display("FAIL sh_wait: got start/we/mode/rsp %b want 010010", {mem_start, mem_write_enable, mem_mode, rsp_valid});
        end
        mem_done = 1'b1; mem_read_data = 32'h5555_5555;
        tick();
        mem_done = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_error} !== 2'b10 || rsp_rdata !== 32'd0) begin
            n_err++; $display("FAIL sh_rsp: got v=%b e=%b d=%h want 1 0 00000000", rsp_valid, rsp_error, rsp_rdata);
        end
        tick();
        n_vec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || start_cnt - s0 != 1 || rsp_cnt - r0 != 1) begin
            n_err++; $display("FAIL sh_after: got v=%b rdy=%b starts=%0d rsps=%0d want 0 1 1 1",
                              rsp_valid, req_ready, start_cnt - s0, rsp_cnt - r0);
        end
        $display("txn SH  addr=00000202 wdata=1234abcd err=%b rdata=%h", rsp_error, rsp_rdata);
    endtask

    task automatic test_load_word;
        int s0 = start_cnt;
        logic held_ok = 1'b1;
        drive_req(32'h100, 3'b010, 1'b0, 32'h0);
        mem_active = 1'b1;
        n_vec++;
        if ({mem_start, mem_write_enable, mem_mode, req_ready} !== 6'b1_0_010_0) begin
            n_err++; $display("FAIL lw_issue: got start/we/mode/rdy %b want 100100", {mem_start, mem_write_enable, mem_mode, req_ready});
        end
        n_vec++;
        if (mem_address !== 32'h100) begin
            n_err++; $display("FAIL lw_addr: got %h want 00000100", mem_address);
        end
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (mem_start !== 1'b0 || mem_mode !== 3'b010 || rsp_valid !== 1'b0) held_ok = 1'b0;
            if (c == 5) begin
                mem_done = 1'b1; mem_read_data = 32'hDEADBEEF;
            end
        end
        n_vec++;
        if (held_ok !== 1'b1) begin
            n_err++; $display("FAIL lw_hold: got unstable wait outputs (ok=%b) want ok=1", held_ok);
        end
        tick();
        mem_done = 1'b0; mem_active = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_error} !== 2'b10 || rsp_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL lw_rsp: got v=%b e=%b d=%h want 1 0 deadbeef", rsp_valid, rsp_error, rsp_rdata);
        end
        n_vec++;
        if (start_cnt - s0 != 1) begin
            n_err++; $display("FAIL lw_starts: got %0d want 1", start_cnt - s0);
        end
        tick();
        n_vec++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL lw_after: got v=%b rdy=%b d=%h want 0 1 deadbeef", rsp_valid, req_ready, rsp_rdata);
        end
        $display("txn LW  addr=00000100 err=%b rdata=%h", rsp_error, rsp_rdata);
    endtask

    task automatic test_misaligned;
        int s0 = start_cnt;
        drive_req(32'h1001, 3'b001, 1'b0, 32'h0);
        n_vec++;
        if ({rsp_valid, rsp_error, mem_start, req_ready} !== 4'b1100 || rsp_rdata !== 32'd0) begin
            n_err++; $display("FAIL lh_mis_rsp: got v/e/start/rdy %b d=%h want 1100 00000000",
                              {rsp_valid, rsp_error, mem_start, req_ready}, rsp_rdata);
        end
        n_vec++;
        if (mem_address !== 32'h1001) begin
            n_err++; $display("FAIL lh_mis_latch: got %h want 00001001", mem_address);
        end
        tick();
        n_vec++;
        if ({req_ready, rsp_valid, rsp_error} !== 3'b101 || start_cnt != s0) begin
            n_err++; $display("FAIL lh_mis_after: got rdy/v/e %b starts=%0d want 101 0",
                              {req_ready, rsp_valid, rsp_error}, start_cnt - s0);
        end
        $display("txn LH  addr=00001001 err=%b rdata=%h", rsp_error, rsp_rdata);
    endtask

    task automatic test_illegal;
        int s0 = start_cnt;
        for (int i = 0; i < 6; i++) begin
            drive_req(bad_addr[i], bad_mode[i], bad_we[i], 32'hFFFF_FFFF);
            n_vec++;
            if ({rsp_valid, rsp_error, mem_start} !== 3'b110 || rsp_rdata !== 32'd0) begin
                n_err++; $display("FAIL illegal_%0d: got v/e/start %b d=%h want 110 00000000",
                                  i, {rsp_valid, rsp_error, mem_start}, rsp_rdata);
            end
            tick();
            n_vec++;
            if ({req_ready, rsp_valid} !== 2'b10) begin
                n_err++; $display("FAIL illegal_%0d_after: got rdy/v %b want 10", i, {req_ready, rsp_valid});
            end
            $display("txn BAD we=%b mode=%b addr=%h err=%b", bad_we[i], bad_mode[i], bad_addr[i], rsp_error);
        end
        n_vec++;
        if (start_cnt != s0) begin
            n_err++; $display("FAIL illegal_starts: got %0d want 0", start_cnt - s0);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout;
        int r0 = rsp_cnt;
        logic quiet = 1'b1;
        drive_req(32'h80, 3'b010, 1'b0, 32'h0);
        for (int c = 2; c <= 17; c++) begin
            tick();
            if (rsp_valid !== 1'b0) quiet = 1'b0;
        end
        tick();
        n_vec++;
        if (quiet !== 1'b1 || {rsp_valid, rsp_error} !== 2'b11 || rsp_rdata !== 32'd0) begin
            n_err++; $display("FAIL timeout_rsp: got early=%b v=%b e=%b d=%h want 0 1 1 00000000",
                              !quiet, rsp_valid, rsp_error, rsp_rdata);
        end
        tick();
        mem_done = 1'b1; mem_read_data = 32'h1111_2222;
        tick();
        mem_done = 1'b0;
        tick(); tick();
        n_vec++;
        if (rsp_cnt - r0 != 1 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL timeout_late_done: got rsps=%0d rdy=%b want 1 1", rsp_cnt - r0, req_ready);
        end
        $display("txn LW  addr=00000080 timeout err=%b", rsp_error);
        drive_req(32'h84, 3'b010, 1'b0, 32'h0);
        for (int c = 2; c <= 17; c++) begin
            tick();
            if (c == 17) begin
                mem_done = 1'b1; mem_read_data = 32'h0BADCAFE;
            end
        end
        tick();
        mem_done = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_error} !== 2'b10 || rsp_rdata !== 32'h0BADCAFE) begin
            n_err++; $display("FAIL timeout_edge_done: got v=%b e=%b d=%h want 1 0 0badcafe", rsp_valid, rsp_error, rsp_rdata);
        end
        tick();
        $display("txn LW  addr=00000084 done-at-limit err=%b rdata=%h", rsp_error, rsp_rdata);
    endtask
`else
    task automatic test_wait_hold;
        logic quiet = 1'b1;
        drive_req(32'h80, 3'b010, 1'b0, 32'h0);
        for (int c = 2; c <= 31; c++) begin
            tick();
            if (rsp_valid !== 1'b0 || req_ready !== 1'b0) quiet = 1'b0;
            if (c == 31) begin
                mem_done = 1'b1; mem_read_data = 32'hCAFEF00D;
            end
        end
        n_vec++;
        if (quiet !== 1'b1) begin
            n_err++; $display("FAIL wait_hold: got premature response/ready want none");
        end
        tick();
        mem_done = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_error} !== 2'b10 || rsp_rdata !== 32'hCAFEF00D) begin
            n_err++; $display("FAIL wait_hold_rsp: got v=%b e=%b d=%h want 1 0 cafef00d", rsp_valid, rsp_error, rsp_rdata);
        end
        tick();
        $display("txn LW  addr=00000080 long-wait err=%b rdata=%h", rsp_error, rsp_rdata);
    endtask
`endif

    task automatic test_stray_done;
        int r0 = rsp_cnt;
        logic [31:0] prev = rsp_rdata;
        mem_done = 1'b1; mem_read_data = 32'h77;
        tick();
        mem_done = 1'b0;
        tick(); tick();
        n_vec++;
        if (rsp_cnt != r0 || rsp_rdata !== prev || req_ready !== 1'b1) begin
            n_err++; $display("FAIL stray_idle: got rsps=%0d d=%h rdy=%b want 0 %h 1", rsp_cnt - r0, rsp_rdata, req_ready, prev);
        end
        drive_req(32'h7, 3'b100, 1'b0, 32'h0);
        mem_done = 1'b1; mem_read_data = 32'h11;
        tick();
        mem_done = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL stray_issue: got v=%b want 0", rsp_valid);
        end
        tick();
        mem_done = 1'b1; mem_read_data = 32'hA5;
        tick();
        mem_done = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_error} !== 2'b10 || rsp_rdata !== 32'hA5 || rsp_cnt - r0 != 0) begin
            n_err++; $display("FAIL stray_rsp: got v=%b e=%b d=%h prior=%0d want 1 0 000000a5 0",
                              rsp_valid, rsp_error, rsp_rdata, rsp_cnt - r0);
        end
        tick();
        $display("txn LBU addr=00000007 err=%b rdata=%h", rsp_error, rsp_rdata);
    endtask

    task automatic test_reset_mid_wait;
        int s0 = start_cnt;
        int r0 = rsp_cnt;
        drive_req(32'h40, 3'b010, 1'b0, 32'h0);
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        mem_done = 1'b1; mem_read_data = 32'h99;
        n_vec++;
        if (req_ready !== 1'b1 || rsp_rdata !== 32'd0 || mem_address !== 32'd0 ||
            {rsp_valid, rsp_error, mem_start, mem_write_enable, mem_mode} !== 7'b0) begin
            n_err++; $display("FAIL rst_mid_outputs: got rdy=%b d=%h a=%h ctrl=%b want 1 0 0 0000000", req_ready, rsp_rdata,
                              mem_address, {rsp_valid, rsp_error, mem_start, mem_write_enable, mem_mode});
        end
        tick();
        mem_done = 1'b0;
        tick(); tick();
        n_vec++;
        if (rsp_cnt != r0 || start_cnt - s0 != 1 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL rst_mid_quiet: got rsps=%0d starts=%0d rdy=%b want 0 1 1", rsp_cnt - r0, start_cnt - s0, req_ready);
        end
        $display("txn LW  addr=00000040 aborted by reset rsps=%0d", rsp_cnt - r0);
        drive_req(32'h3, 3'b000, 1'b0, 32'h0);
        n_vec++;
        if ({mem_start, mem_mode} !== 4'b1000 || mem_address !== 32'h3) begin
            n_err++; $display("FAIL lb_issue: got start/mode %b a=%h want 1000 00000003", {mem_start, mem_mode}, mem_address);
        end
        tick();
        mem_done = 1'b1; mem_read_data = 32'hFFFFFF80;
        tick();
        mem_done = 1'b0;
        n_vec++;
        if ({rsp_valid, rsp_error} !== 2'b10 || rsp_rdata !== 32'hFFFFFF80) begin
            n_err++; $display("FAIL lb_rsp: got v=%b e=%b d=%h want 1 0 ffffff80", rsp_valid, rsp_error, rsp_rdata);
        end
        tick();
        $display("txn LB  addr=00000003 err=%b rdata=%h", rsp_error, rsp_rdata);
    endtask

    initial begin
        test_reset();
        test_store_half();
        test_load_word();
        test_misaligned();
        test_illegal();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_wait_hold();
`endif
        test_stray_done();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
